mem_arbiter: RTL and testbench

- Two-master, one-slave memory bus arbiter.
- Sits directly downstream of the data load/store unit (port B) and the instruction prefetch unit (port A), and drives the single external memory port (port Q).
- Grants one master at a time with a registered grant that is held until the slave acks.
- Uses round-robin tie-breaking so that neither prefetch nor data accesses starve.

---
 rtl/mem_arbiter_pkg.sv | 15 +
 rtl/mem_arbiter.sv | 108 ++++++++++
 tb/tb_mem_arbiter.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared bus constants and arbiter state encoding for the memory arbiter
// and the prefetch / load-store units that drive it.
package mem_arbiter_pkg;

    localparam int ADDR_W = 19;
    localparam int DATA_W = 16;
    localparam int BSEL_W = 2;

    typedef logic [1:0] arb_state_t;

    localparam arb_state_t ARB_IDLE    = 2'd0;
    localparam arb_state_t ARB_GRANT_A = 2'd1;
    localparam arb_state_t ARB_GRANT_B = 2'd2;

endpackage

// File: rtl/mem_arbiter.sv
// Two-master (A = prefetch, B = load/store) to one-slave memory bus arbiter
// with a registered round-robin grant held until the slave acks.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter bit B_FIRST = 1'b1
) (
    input  logic              clk,
    input  logic              reset,

    input  logic [ADDR_W-1:0] a_m_addr,
    output logic [DATA_W-1:0] a_m_data_in,
    input  logic [DATA_W-1:0] a_m_data_out,
    input  logic              a_m_access,
    output logic              a_m_ack,
    input  logic              a_m_wr_en,
    input  logic [BSEL_W-1:0] a_m_bytesel,

    input  logic [ADDR_W-1:0] b_m_addr,
    output logic [DATA_W-1:0] b_m_data_in,
    input  logic [DATA_W-1:0] b_m_data_out,
    input  logic              b_m_access,
    output logic              b_m_ack,
    input  logic              b_m_wr_en,
    input  logic [BSEL_W-1:0] b_m_bytesel,

    output logic [ADDR_W-1:0] q_m_addr,
    input  logic [DATA_W-1:0] q_m_data_in,
    output logic [DATA_W-1:0] q_m_data_out,
    output logic              q_m_access,
    input  logic              q_m_ack,
    output logic              q_m_wr_en,
    output logic [BSEL_W-1:0] q_m_bytesel,

    output arb_state_t        dbg_state
);

    // Handshake: a master holds *_m_access (and its address/data) until it
    // sees its own *_m_ack; an ack completes exactly one cycle on that edge.
    arb_state_t state;
    arb_state_t state_next;
    logic       last_b;

    always_comb begin
        state_next = state;
        case (state)
            ARB_IDLE: begin
                if (a_m_access && b_m_access)
                    state_next = last_b ? ARB_GRANT_A : ARB_GRANT_B;
                else if (a_m_access)
                    state_next = ARB_GRANT_A;
                else if (b_m_access)
                    state_next = ARB_GRANT_B;
            end
            ARB_GRANT_A, ARB_GRANT_B: begin
                // Always return to IDLE so the master's access can drop.
                if (q_m_ack)
                    state_next = ARB_IDLE;
            end
            default: state_next = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= ARB_IDLE;
            last_b <= (B_FIRST == 1'b0);
        end else begin
            state <= state_next;
            if (q_m_ack && state == ARB_GRANT_A)
                last_b <= 1'b0;
            else if (q_m_ack && state == ARB_GRANT_B)
                last_b <= 1'b1;
        end
    end

    always_comb begin
        q_m_addr     = '0;
        q_m_data_out = '0;
        q_m_access   = 1'b0;
        q_m_wr_en    = 1'b0;
        q_m_bytesel  = '0;
        case (state)
            ARB_GRANT_A: begin
                q_m_addr     = a_m_addr;
                q_m_data_out = a_m_data_out;
                q_m_access   = a_m_access;
                q_m_wr_en    = a_m_wr_en;
                q_m_bytesel  = a_m_bytesel;
            end
            ARB_GRANT_B: begin
                q_m_addr     = b_m_addr;
                q_m_data_out = b_m_data_out;
                q_m_access   = b_m_access;
                q_m_wr_en    = b_m_wr_en;
                q_m_bytesel  = b_m_bytesel;
            end
            default: ;
        endcase
    end

    assign a_m_ack     = q_m_ack && (state == ARB_GRANT_A);
    assign b_m_ack     = q_m_ack && (state == ARB_GRANT_B);
    assign a_m_data_in = q_m_data_in;
    assign b_m_data_in = q_m_data_in;
    assign dbg_state   = state;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: queued master transactions, a reactive slave and a
// transaction-level round-robin model feeding an expected queue.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [ADDR_W-1:0] a_m_addr, b_m_addr, q_m_addr;
  logic [DATA_W-1:0] a_m_data_in, b_m_data_in, q_m_data_in;
  logic [DATA_W-1:0] a_m_data_out, b_m_data_out, q_m_data_out;
  logic a_m_access, b_m_access, q_m_access;
  logic a_m_ack, b_m_ack, q_m_ack;
  logic a_m_wr_en, b_m_wr_en, q_m_wr_en;
  logic [BSEL_W-1:0] a_m_bytesel, b_m_bytesel, q_m_bytesel;
  arb_state_t dbg_state;

  mem_arbiter #(.B_FIRST(1'b1)) dut (
    .clk(clk), .reset(reset),
    .a_m_addr(a_m_addr), .a_m_data_in(a_m_data_in), .a_m_data_out(a_m_data_out),
    .a_m_access(a_m_access), .a_m_ack(a_m_ack), .a_m_wr_en(a_m_wr_en), .a_m_bytesel(a_m_bytesel),
    .b_m_addr(b_m_addr), .b_m_data_in(b_m_data_in), .b_m_data_out(b_m_data_out),
    .b_m_access(b_m_access), .b_m_ack(b_m_ack), .b_m_wr_en(b_m_wr_en), .b_m_bytesel(b_m_bytesel),
    .q_m_addr(q_m_addr), .q_m_data_in(q_m_data_in), .q_m_data_out(q_m_data_out),
    .q_m_access(q_m_access), .q_m_ack(q_m_ack), .q_m_wr_en(q_m_wr_en), .q_m_bytesel(q_m_bytesel),
    .dbg_state(dbg_state)
  );

  // ---------------- bench state ----------------
  int checks = 0;
  int failures = 0;
  // expected item: {owner[1:0] (1=A, 2=B), wr, bytesel[1:0], addr[18:0], data[15:0]}
  logic [39:0] exp_q[$];
  logic [37:0] a_txq[$];
  logic [37:0] b_txq[$];
  int owner = 0;       // master currently holding the bus in the model, 0 = free
  int last_owner = 1;  // last master served; A here means B wins the next tie
  bit mon_en = 1'b0;
  bit hold_a = 1'b0;
  bit stray_en = 1'b0;
  bit force_rd = 1'b0;
  logic [15:0] forced_rdata = 16'h0;
  int slv_cnt = 0;
  int slv_dly = 0;
  int max_dly = 0;
  logic [39:0] mon_e;

  task automatic chk(input string name, input logic [39:0] act, input logic [39:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [37:0] mk_txn(input logic wr, input logic [1:0] bsel,
                                         input logic [18:0] addr, input logic [15:0] data);
    return {wr, bsel, addr, data};
  endfunction

  function automatic logic [37:0] rand_txn();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    return r[37:0];
  endfunction

  // ---------------- reference model ----------------
  // Bus is free or owned; when free and someone asks, the tie goes to the
  // master not served last. Ownership ends on the slave ack.
  task automatic model_update();
    logic [37:0] t;
    if (owner != 0) begin
      if (q_m_ack) begin
        if (owner == 1) void'(a_txq.pop_front());
        else void'(b_txq.pop_front());
        last_owner = owner;
        owner = 0;
      end
    end else if (a_m_access || b_m_access) begin
      if (a_m_access && b_m_access) owner = (last_owner == 1) ? 2 : 1;
      else owner = a_m_access ? 1 : 2;
      t = (owner == 1) ? a_txq[0] : b_txq[0];
      exp_q.push_back({owner[1:0], t});
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_masters();
    a_m_access = (a_txq.size() != 0);
    b_m_access = (b_txq.size() != 0);
    if (a_m_access) {a_m_wr_en, a_m_bytesel, a_m_addr, a_m_data_out} = a_txq[0];
    else {a_m_wr_en, a_m_bytesel, a_m_addr, a_m_data_out} = rand_txn();
    if (b_m_access) {b_m_wr_en, b_m_bytesel, b_m_addr, b_m_data_out} = b_txq[0];
    else {b_m_wr_en, b_m_bytesel, b_m_addr, b_m_data_out} = rand_txn();
  endtask

  task automatic drive_slave();
    q_m_data_in = force_rd ? forced_rdata : 16'($urandom());
    if (hold_a && owner == 1) begin
      q_m_ack = 1'b0;
    end else if (q_m_access) begin
      if (slv_cnt >= slv_dly) begin
        q_m_ack = 1'b1;
        slv_cnt = 0;
        slv_dly = int'($urandom_range(max_dly, 0));
      end else begin
        q_m_ack = 1'b0;
        slv_cnt++;
      end
    end else begin
      q_m_ack = stray_en && (owner == 0) && ($urandom_range(5, 0) == 0);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    model_update();
    drive_masters();
    #1;
    drive_slave();
  endtask

  task automatic run_until_idle(input int max_cyc);
    int n;
    n = 0;
    while ((a_txq.size() != 0 || b_txq.size() != 0 || owner != 0) && n < max_cyc) begin
      step();
      n++;
    end
    chk("drain_budget", 40'(n < max_cyc), 40'(1));
  endtask

  task automatic do_reset();
    mon_en = 1'b0;
    reset = 1'b1;
    a_txq.delete();
    b_txq.delete();
    exp_q.delete();
    owner = 0;
    last_owner = 1;
    hold_a = 1'b0;
    drive_masters();
    q_m_ack = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_q_access", 40'(q_m_access), 40'(0));
    chk("reset_state", 40'(dbg_state), 40'(ARB_IDLE));
    @(posedge clk);
    #1;
    reset = 1'b0;
    mon_en = 1'b1;
    #1;
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (mon_en && !reset) begin
      if (exp_q.size() != 0) begin
        mon_e = exp_q[0];
        chk("q_access", 40'(q_m_access), 40'(1));
        chk("q_addr", 40'(q_m_addr), 40'(mon_e[34:16]));
        chk("q_data_out", 40'(q_m_data_out), 40'(mon_e[15:0]));
        chk("q_wr_en", 40'(q_m_wr_en), 40'(mon_e[37]));
        chk("q_bytesel", 40'(q_m_bytesel), 40'(mon_e[36:35]));
        chk("grant_state", 40'(dbg_state), 40'((mon_e[39:38] == 2'd1) ? ARB_GRANT_A : ARB_GRANT_B));
        chk("a_ack", 40'(a_m_ack), 40'(q_m_ack && mon_e[39:38] == 2'd1));
        chk("b_ack", 40'(b_m_ack), 40'(q_m_ack && mon_e[39:38] == 2'd2));
        if (q_m_ack) begin
          if (mon_e[39:38] == 2'd1) chk("a_rdata", 40'(a_m_data_in), 40'(q_m_data_in));
          else chk("b_rdata", 40'(b_m_data_in), 40'(q_m_data_in));
          void'(exp_q.pop_front());
        end
      end else begin
        chk("idle_q_access", 40'(q_m_access), 40'(0));
        chk("idle_q_addr", 40'(q_m_addr), 40'(0));
        chk("idle_q_data_out", 40'(q_m_data_out), 40'(0));
        chk("idle_q_ctl", 40'({q_m_wr_en, q_m_bytesel}), 40'(0));
        chk("idle_acks", 40'({a_m_ack, b_m_ack}), 40'(0));
        chk("idle_state", 40'(dbg_state), 40'(ARB_IDLE));
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int n;
    reset = 1'b1;
    q_m_ack = 1'b0;
    q_m_data_in = '0;
    drive_masters();
    do_reset();

    // single B read returning BEEF
    force_rd = 1'b1;
    forced_rdata = 16'hBEEF;
    b_txq.push_back(mk_txn(1'b0, 2'b11, 19'h00400, 16'h0000));
    run_until_idle(20);
    force_rd = 1'b0;

    // B write passthrough
    max_dly = 3;
    b_txq.push_back(mk_txn(1'b1, 2'b10, 19'h01234, 16'h3400));
    run_until_idle(30);
    step();

    // simultaneous requests after reset: B, A, B, A ...
    do_reset();
    for (int i = 0; i < 3; i++) begin
      a_txq.push_back(mk_txn(1'b0, 2'b11, 19'h7FFF0, 16'($urandom())));
      b_txq.push_back(mk_txn(1'b0, 2'b01, 19'h00400 + 19'(i), 16'($urandom())));
    end
    run_until_idle(100);
    step();

    // reset while A is granted, then tie resolves to B again
    a_txq.push_back(mk_txn(1'b0, 2'b11, 19'h7FFF0, 16'h1111));
    b_txq.push_back(mk_txn(1'b1, 2'b11, 19'h00010, 16'h2222));
    hold_a = 1'b1;
    n = 0;
    while (owner != 1 && n < 40) begin
      step();
      n++;
    end
    chk("reach_grant_a", 40'(owner), 40'(1));
    step();
    #1;
    chk("pre_reset_access", 40'(q_m_access), 40'(1));
    mon_en = 1'b0;
    reset = 1'b1;
    #1;
    chk("async_reset_access", 40'(q_m_access), 40'(0));
    chk("async_reset_state", 40'(dbg_state), 40'(ARB_IDLE));
    do_reset();
    a_txq.push_back(mk_txn(1'b0, 2'b11, 19'h7FFF0, 16'h3333));
    b_txq.push_back(mk_txn(1'b0, 2'b11, 19'h00020, 16'h4444));
    step();
    step();
    chk("post_reset_first_grant", 40'(dbg_state), 40'(ARB_GRANT_B));
    run_until_idle(60);
    step();

    // stray ack in IDLE
    step();
    q_m_ack = 1'b1;
    step();
    #1;
    chk("stray_state", 40'(dbg_state), 40'(ARB_IDLE));
    chk("stray_acks", 40'({a_m_ack, b_m_ack}), 40'(0));
    step();

    // starvation: A continuously busy for 20 transactions, B every other cycle
    for (int i = 0; i < 20; i++) a_txq.push_back(rand_txn());
    n = 0;
    while (a_txq.size() != 0 && n < 600) begin
      step();
      n++;
      if (n % 2 == 0 && b_txq.size() == 0) b_txq.push_back(rand_txn());
    end
    chk("starve_budget", 40'(n < 600), 40'(1));
    run_until_idle(100);

    // random traffic with stray acks
    stray_en = 1'b1;
    for (int c = 0; c < 400; c++) begin
      if (a_txq.size() < 2 && $urandom_range(2, 0) == 0) a_txq.push_back(rand_txn());
      if (b_txq.size() < 2 && $urandom_range(2, 0) == 0) b_txq.push_back(rand_txn());
      step();
    end
    stray_en = 1'b0;
    run_until_idle(300);
    step();
    step();

    chk("scoreboard_empty", 40'(exp_q.size()), 40'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
